fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH SHALL be: DEPTH, default 4, number of entries; power of two, minimum 2.
REQ-002 Parameter CW SHALL be: CW, default $clog2(DEPTH)+1, width of the count output.
REQ-003 Port clk SHALL be: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset SHALL be: reset  input  1  asynchronous, active-low reset.
REQ-005 Port in_valid SHALL be: in_valid  input  1  the fetch stage presents a {pc, instr} pair.
REQ-006 Port in_pc SHALL be: in_pc  input  32  address of the fetched instruction.
REQ-007 Port in_instr SHALL be: in_instr  input  32  fetched instruction word.
REQ-008 Port in_ready SHALL be: in_ready  output  1  queue can accept a pair this cycle.
REQ-009 Port out_valid SHALL be: out_valid  output  1  head entry is available to decode.
REQ-010 Port out_pc SHALL be: out_pc  output  32  head entry address.
REQ-011 Port out_instr SHALL be: out_instr  output  32  head entry instruction.
REQ-012 Port out_ready SHALL be: out_ready  input  1  decode consumes the head this cycle.
REQ-013 Port flush SHALL be: flush  input  1  branch/jump redirect; discard all queued entries.
REQ-014 Port count SHALL be: count  output  CW  number of valid entries.

Function
REQ-015 A push SHALL occur on a clock edge where in_valid=1, in_ready=1 and flush=0.
REQ-016 A pop SHALL occur on a clock edge where out_valid=1, out_ready=1 and flush=0.
REQ-017 in_ready SHALL equal (count != DEPTH) and SHALL NOT depend combinationally on out_ready.
REQ-018 out_valid SHALL equal (count != 0), driven only from registered state.
REQ-019 out_pc and out_instr SHALL show the oldest entry when out_valid=1, and SHALL be 32'h00000000 when out_valid=0.
REQ-020 A pushed pair SHALL first appear at the outputs one cycle after its push edge. There is no same-cycle bypass.
REQ-021 Entries SHALL leave the queue in strict FIFO order.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH.
REQ-023 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-024 When full, in_valid SHALL be ignored, even if a pop occurs in the same cycle.
REQ-025 When empty, out_ready SHALL be ignored.
REQ-026 flush=1 SHALL take priority over push and pop.
REQ-027 On a flush edge, count, the read pointer and the write pointer SHALL all go to 0, and any concurrent push SHALL be dropped.
REQ-028 In the cycle after a flush, out_valid SHALL be 0 and in_ready SHALL be 1.
REQ-029 count SHALL update on the same edge as each push, pop or flush.

Reset
REQ-030 reset=0 SHALL asynchronously clear count and both pointers, independent of clk.
REQ-031 While reset=0: out_valid=0, in_ready=1, out_pc=0, out_instr=0.
REQ-032 Storage contents SHALL need no reset, because REQ-019 masks them.
REQ-033 After reset is released, the first push SHALL be accepted on the next rising edge.
REQ-034 If reset is asserted mid-operation, all queued entries SHALL be lost, and no pop SHALL be reported on the release edge.

Structure
REQ-035 A shared package SHALL hold the default DEPTH, the 64-bit entry width constant and the {pc, instr} entry typedef.
REQ-036 Storage SHALL be a single sub-module, fetch_queue_mem: DEPTH x 64 bits, one write port, one asynchronous read port, no reset.
REQ-037 Pointer, count and handshake control SHALL reside in fetch_queue itself.

Verification
REQ-038 Fill: reset, then push pc=0x3000,0x3004,0x3008,0x300C with out_ready=0 -> count=4, in_ready=0, out_pc=0x3000.
REQ-039 Drain order: from the full state, out_ready=1 for 4 cycles -> out_pc sequence 0x3000,0x3004,0x3008,0x300C, then out_valid=0 and out_pc=0.
REQ-040 Streaming: count=2 with continuous push and pop for 10 cycles -> count stays 2, pointers wrap, order is preserved, no entry is lost or duplicated.
REQ-041 Flush collision: count=3, with flush=1, in_valid=1 (pc=0x4000) and out_ready=1 on the same edge -> next cycle count=0, out_valid=0, 0x4000 is not queued.
REQ-042 Full-plus-pop: count=4, in_valid=1 (pc=0x5000) and out_ready=1 -> count=3, 0x5000 is not accepted.
REQ-043 Async reset: drop reset between clock edges with count=2 -> count=0 and out_valid=0 immediately, before the next edge.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: default depth,
// entry width and the {pc, instr} entry layout.
package fetch_queue_pkg;

    localparam int FQ_DEPTH_DEFAULT = 4;
    localparam int FQ_ENTRY_W       = 64;

    // One queued fetch result; pc occupies the upper half.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: DEPTH x 64 bits, one synchronous
// write port and one asynchronous read port. Contents are never reset;
// the control logic masks the read data whenever the queue is empty.
module fetch_queue_mem
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  fq_entry_t     wdata,
    input  logic [AW-1:0] raddr,
    output fq_entry_t     rdata
);

    fq_entry_t mem [DEPTH];

    // Write the incoming entry into its slot on an accepted push.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode. Holds up to DEPTH
// {pc, instr} pairs in FIFO order. Pointers and count are registered, so
// in_ready and out_valid never depend combinationally on the opposite side.
// A flush (branch redirect) empties the queue and overrides push/pop.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH_DEFAULT,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_instr,
    output logic          in_ready,
    output logic          out_valid,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_instr,
    input  logic          out_ready,
    input  logic          flush,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          push;
    logic          pop;
    fq_entry_t     wr_entry;
    fq_entry_t     rd_entry;

    // Handshakes derive only from registered count, so a full queue
    // rejects a push even when decode pops on the same edge.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid  & in_ready  & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    assign wr_entry.pc    = in_pc;
    assign wr_entry.instr = in_instr;

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    // Stale storage is hidden whenever there is no valid head entry.
    assign out_pc    = out_valid ? rd_entry.pc    : 32'h0000_0000;
    assign out_instr = out_valid ? rd_entry.instr : 32'h0000_0000;

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: the stimulus process queues each entry
// it expects to be accepted; a monitor pops and compares on every pop.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [31:0]   in_pc = '0;
    logic [31:0]   in_instr = '0;
    logic          in_ready;
    logic          out_valid;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic          out_ready = 1'b0;
    logic          flush = 1'b0;
    logic [CW-1:0] count;

    int tests = 0;
    int fails = 0;

    logic [63:0] exp_q [$];

    fetch_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .flush     (flush),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive inputs, check in_ready before the edge,
    // record the entry if it should be accepted, return #1 after the edge.
    task automatic drive(input logic v, input logic [31:0] pc, input logic ordy,
                         input logic fl, input logic exp_rdy);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = instr_of(pc);
        out_ready = ordy;
        flush     = fl;
        if (fl) exp_q.delete();
        else if (v && exp_rdy) exp_q.push_back({pc, instr_of(pc)});
        @(negedge clk);
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    // Monitor: every pop the DUT will take on the coming edge is checked
    // against the oldest expected entry.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL pop_unexpected: got pc %h expected no entry", out_pc);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("pop_pc", out_pc, e[63:32]);
                chk("pop_instr", out_instr, e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #1 reset = 1'b0;
        #2;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Fill
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h3000 + 32'(4*i), 1'b0, 1'b0, 1'b1);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_in_ready", {31'b0, in_ready}, 32'd0);
        chk("fill_out_pc", out_pc, 32'h3000);

        // Drain order (monitor checks 0x3000..0x300C)
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("drain_out_valid", {31'b0, out_valid}, 32'd0);
        chk("drain_out_pc", out_pc, 32'h0);
        chk("drain_count", 32'(count), 32'd0);

        // Streaming at count=2 with pointer wrap
        drive(1'b1, 32'h6000, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h6004, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h6008 + 32'(4*i), 1'b1, 1'b0, 1'b1);
            chk("stream_count", 32'(count), 32'd2);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("stream_empty", {31'b0, out_valid}, 32'd0);

        // Flush collision with push and pop
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h7000 + 32'(4*i), 1'b0, 1'b0, 1'b1);
        chk("pre_flush_count", 32'(count), 32'd3);
        drive(1'b1, 32'h4000, 1'b1, 1'b1, 1'b1);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
        chk("flush_out_pc", out_pc, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("flush_nothing_queued", {31'b0, out_valid}, 32'd0);

        // Full plus pop: 0x5000 must be rejected
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h8000 + 32'(4*i), 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h5000, 1'b1, 1'b0, 1'b0);
        chk("fullpop_count", 32'(count), 32'd3);
        chk("fullpop_head", out_pc, 32'h8004);
        for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("fullpop_empty", {31'b0, out_valid}, 32'd0);

        // Asynchronous reset between edges
        drive(1'b1, 32'h9000, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h9004, 1'b0, 1'b0, 1'b1);
        chk("pre_arst_count", 32'(count), 32'd2);
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("arst_out_pc", out_pc, 32'h0);
        out_ready = 1'b1;
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("post_arst_count", 32'(count), 32'd0);
        chk("post_arst_out_valid", {31'b0, out_valid}, 32'd0);
        drive(1'b1, 32'hA000, 1'b0, 1'b0, 1'b1);
        chk("post_arst_push_count", 32'(count), 32'd1);
        chk("post_arst_push_pc", out_pc, 32'hA000);
        chk("post_arst_push_instr", out_instr, instr_of(32'hA000));
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
